// File: rtl/bus_tx_ctrl_if.sv
// Signal bundle between a word source, the bus arbiter and bus_tx_ctrl.
// Word handshake: tx_data is taken on a rising edge where tx_valid && tx_ready are both high;
// tx_valid/tx_data may be held or changed freely while tx_ready is low.
interface bus_tx_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             bus_req;
  logic             bus_gnt;
  logic             data_out;
  logic             data_enable_low;
  logic             done;
  logic             abort;

  // master: the transmit controller itself; slave: word source plus arbiter side
  modport master (
    input  tx_data, tx_valid, bus_gnt,
    output tx_ready, bus_req, data_out, data_enable_low, done, abort
  );

  modport slave (
    output tx_data, tx_valid, bus_gnt,
    input  tx_ready, bus_req, data_out, data_enable_low, done, abort
  );
endinterface

// File: rtl/bus_tx_ctrl.sv
// Upstream controller for the shared 1-bit tristate bus: takes a word, requests the bus,
// shifts the word out LSB-first while enabled, then releases the bus for a turnaround gap.
module bus_tx_ctrl #(
  parameter int WIDTH      = 8,
  parameter int TURNAROUND = 2
) (
  input  logic               clk,
  input  logic               rst,
  bus_tx_ctrl_if.master      bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRIVE = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [TW-1:0] LAST_TURN = TW'(TURNAROUND - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [TW-1:0]    turn_cnt;

  assign bus.tx_ready = (state == IDLE);
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      shreg               <= '0;
      bit_cnt             <= '0;
      turn_cnt            <= '0;
      bus.bus_req         <= 1'b0;
      bus.data_out        <= 1'b0;
      bus.data_enable_low <= 1'b1;
      bus.done            <= 1'b0;
      bus.abort           <= 1'b0;
    end else begin
      bus.done  <= 1'b0;
      bus.abort <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.tx_valid) begin
            shreg       <= bus.tx_data;
            bus.bus_req <= 1'b1;
            state       <= REQ;
          end
        end

        REQ: begin
          // bit 0 goes on the bus in the cycle right after the grant edge
          if (bus.bus_gnt) begin
            bus.data_enable_low <= 1'b0;
            bus.data_out        <= shreg[0];
            shreg               <= shreg >> 1;
            bit_cnt             <= '0;
            state               <= DRIVE;
          end
        end

        DRIVE: begin
          // the edge ending the last bit completes the word even if the grant drops there
          if (bit_cnt == LAST_BIT || !bus.bus_gnt) begin
            bus.done            <= (bit_cnt == LAST_BIT);
            bus.abort           <= (bit_cnt != LAST_BIT);
            bus.data_enable_low <= 1'b1;
            bus.data_out        <= 1'b0;
            bus.bus_req         <= 1'b0;
            shreg               <= '0;
            turn_cnt            <= '0;
            state               <= TURN;
          end else begin
            bus.data_out <= shreg[0];
            shreg        <= shreg >> 1;
            bit_cnt      <= bit_cnt + 1'b1;
          end
        end

        TURN: begin
          if (turn_cnt == LAST_TURN) begin
            state <= IDLE;
          end else begin
            turn_cnt <= turn_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_tx_ctrl.sv
// Bench for bus_tx_ctrl: directed scenarios plus randomized traffic, all checked every cycle
// against a transaction-level model and a word scoreboard.
module tb_bus_tx_ctrl;
  localparam int W = 8;
  localparam int T = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_tx_ctrl_if #(.WIDTH(W)) bif ();
  bus_tx_ctrl_if #(.WIDTH(1)) bif1 ();
  logic [1:0] dbg_state;
  logic [1:0] dbg_state1;

  bus_tx_ctrl #(.WIDTH(W), .TURNAROUND(T)) u_dut (
    .clk(clk), .rst(rst), .bus(bif), .dbg_state(dbg_state)
  );
  bus_tx_ctrl #(.WIDTH(1), .TURNAROUND(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bif1), .dbg_state(dbg_state1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_abort = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Word-level view: a held word, whether it owns the bus, which bit is on the wire,
  // and how many released cycles remain before a new word may be taken.
  bit             m_have    = 1'b0;
  bit             m_owns    = 1'b0;
  int             m_idx     = 0;
  int             m_cool    = 0;
  logic [W-1:0]   m_word    = '0;
  bit             m_done    = 1'b0;
  bit             m_abort   = 1'b0;
  bit             m_prev_gnt = 1'b0;
  logic [W-1:0]   exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_have = 0; m_owns = 0; m_idx = 0; m_cool = 0; m_word = '0;
      m_done = 0; m_abort = 0; m_prev_gnt = 0;
      exp_q.delete();
    end else begin
      m_prev_gnt = bif.bus_gnt;
      m_done     = 0;
      m_abort    = 0;
      if (m_cool > 0) begin
        m_cool--;
      end else if (!m_have) begin
        if (bif.tx_valid) begin
          m_have = 1; m_owns = 0; m_word = bif.tx_data;
          exp_q.push_back(bif.tx_data);
        end
      end else if (!m_owns) begin
        if (bif.bus_gnt) begin m_owns = 1; m_idx = 0; end
      end else if (m_idx == W - 1 || !bif.bus_gnt) begin
        m_done  = (m_idx == W - 1);
        m_abort = !m_done;
        m_have = 0; m_owns = 0; m_cool = T;
      end else begin
        m_idx++;
      end
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  logic [W-1:0] rx_word = '0;
  int           rx_cnt  = 0;

  always @(negedge clk) begin
    if (rst) begin
      rx_cnt = 0;
    end else begin
      check("tx_ready", bif.tx_ready, (!m_have && m_cool == 0));
      check("bus_req", bif.bus_req, m_have);
      check("data_enable_low", bif.data_enable_low, !(m_have && m_owns));
      check("data_out", bif.data_out, (m_have && m_owns) ? m_word[m_idx] : 1'b0);
      check("done", bif.done, m_done);
      check("abort", bif.abort, m_abort);
      if (!bif.data_enable_low) begin
        check("drive_after_gnt", m_prev_gnt, 1);
        if (rx_cnt < W) rx_word[rx_cnt] = bif.data_out;
        rx_cnt++;
      end
      if (bif.done) begin
        n_done++;
        check("sb_bits", rx_cnt, W);
        check("sb_depth", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("sb_word", rx_word, exp_q.pop_front());
        rx_cnt = 0;
      end
      if (bif.abort) begin
        n_abort++;
        check("sb_depth_abort", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        rx_cnt = 0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_drive();
    int guard;
    guard = 0;
    while (bif.data_enable_low && guard < 20) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic collect(output logic [W-1:0] word, output int nbits);
    word  = '0;
    nbits = 0;
    wait_drive();
    while (!bif.data_enable_low && nbits < 16) begin
      if (nbits < W) word[nbits] = bif.data_out;
      nbits++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] got;
    int           nb;
    logic         el_hist [0:29];
    bit           drop;
    int           s1, e1, s2, e2, pct;

    bif.tx_data = '0; bif.tx_valid = 0; bif.bus_gnt = 0;
    bif1.tx_data = '0; bif1.tx_valid = 0; bif1.bus_gnt = 0;
    repeat (3) @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    check("rst_tx_ready", bif.tx_ready, 1);
    check("rst_en_low", bif.data_enable_low, 1);
    check("rst_bus_req", bif.bus_req, 0);
    check("rst_data_out", bif.data_out, 0);
    check("rst_done", bif.done, 0);

    // async reset taken mid-cycle while requesting
    bif.tx_data = 8'h5A; bif.tx_valid = 1;
    @(negedge clk);
    bif.tx_valid = 0;
    @(negedge clk);
    check("req_bus_req", bif.bus_req, 1);
    #2 rst = 1;
    #1;
    check("async_bus_req", bif.bus_req, 0);
    check("async_en_low", bif.data_enable_low, 1);
    check("async_tx_ready", bif.tx_ready, 1);
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);

    // basic word, grant three cycles after the request
    bif.tx_data = 8'hA5; bif.tx_valid = 1;
    @(negedge clk);
    bif.tx_valid = 0;
    repeat (2) @(negedge clk);
    bif.bus_gnt = 1;
    collect(got, nb);
    check("a5_word", got, 8'hA5);
    check("a5_bits", nb, 8);
    check("a5_done", bif.done, 1);
    check("a5_abort", bif.abort, 0);
    @(negedge clk);
    check("a5_turn_ready", bif.tx_ready, 0);
    check("a5_turn_en", bif.data_enable_low, 1);
    @(negedge clk);
    check("a5_idle_ready", bif.tx_ready, 1);
    bif.bus_gnt = 0;

    // back-to-back words with the grant tied high
    bif.bus_gnt = 1; bif.tx_data = 8'h01; bif.tx_valid = 1;
    @(negedge clk);
    bif.tx_data = 8'h80;
    drop = 0;
    for (int i = 0; i < 30; i++) begin
      el_hist[i] = bif.data_enable_low;
      if (drop) bif.tx_valid = 0;
      else if (bif.tx_ready) drop = 1;
      @(negedge clk);
    end
    s1 = -1; e1 = -1; s2 = -1; e2 = -1;
    for (int i = 0; i < 30; i++) begin
      if (s1 < 0) begin if (!el_hist[i]) s1 = i; end
      else if (e1 < 0) begin if (el_hist[i]) e1 = i; end
      else if (s2 < 0) begin if (!el_hist[i]) s2 = i; end
      else if (e2 < 0) begin if (el_hist[i]) e2 = i; end
    end
    check("b2b_len1", e1 - s1, W);
    // released gap: TURNAROUND cycles, one IDLE accept cycle, one REQ cycle
    check("b2b_gap", s2 - e1, T + 2);
    check("b2b_len2", e2 - s2, W);
    bif.bus_gnt = 0;
    repeat (4) @(negedge clk);

    // grant lost after bit 3 of 8'hFF
    bif.tx_data = 8'hFF; bif.tx_valid = 1; bif.bus_gnt = 1;
    @(negedge clk);
    bif.tx_valid = 0;
    wait_drive();
    nb = 0;
    while (!bif.data_enable_low && nb < 16) begin
      nb++;
      if (nb == 4) bif.bus_gnt = 0;
      @(negedge clk);
    end
    check("loss_bits", nb, 4);
    check("loss_abort", bif.abort, 1);
    check("loss_done", bif.done, 0);
    check("loss_dout", bif.data_out, 0);
    @(negedge clk);
    check("loss_turn_ready", bif.tx_ready, 0);
    @(negedge clk);
    check("loss_idle_ready", bif.tx_ready, 1);

    // reset while bit 5 is on the bus, then a clean word
    bif.tx_data = 8'hC3; bif.tx_valid = 1; bif.bus_gnt = 1;
    @(negedge clk);
    bif.tx_valid = 0;
    wait_drive();
    nb = 0;
    while (!bif.data_enable_low && nb < 6) begin
      nb++;
      if (nb < 6) @(negedge clk);
    end
    check("mid_bit_index", nb, 6);
    check("mid_driving", bif.data_enable_low, 0);
    #2 rst = 1;
    #1;
    check("mid_rst_en_low", bif.data_enable_low, 1);
    check("mid_rst_bus_req", bif.bus_req, 0);
    check("mid_rst_dout", bif.data_out, 0);
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    check("post_rst_ready", bif.tx_ready, 1);
    check("post_rst_en", bif.data_enable_low, 1);
    bif.tx_data = 8'h3C; bif.tx_valid = 1;
    @(negedge clk);
    bif.tx_valid = 0;
    collect(got, nb);
    check("3c_word", got, 8'h3C);
    check("3c_bits", nb, 8);
    check("3c_done", bif.done, 1);
    bif.bus_gnt = 0;
    repeat (3) @(negedge clk);

    // single-bit word, single turnaround cycle
    bif1.tx_data = 1'b1; bif1.tx_valid = 1; bif1.bus_gnt = 1;
    @(negedge clk);
    bif1.tx_valid = 0;
    check("w1_req", bif1.bus_req, 1);
    check("w1_req_en", bif1.data_enable_low, 1);
    @(negedge clk);
    check("w1_drive_en", bif1.data_enable_low, 0);
    check("w1_drive_bit", bif1.data_out, 1);
    @(negedge clk);
    check("w1_turn_en", bif1.data_enable_low, 1);
    check("w1_done", bif1.done, 1);
    check("w1_turn_ready", bif1.tx_ready, 0);
    @(negedge clk);
    check("w1_idle_ready", bif1.tx_ready, 1);
    check("w1_done_clear", bif1.done, 0);
    bif1.bus_gnt = 0;

    // randomized traffic with varying grant reliability
    for (int c = 0; c < 3000; c++) begin
      pct = (c < 1000) ? 70 : (c < 2000) ? 93 : 100;
      bif.tx_valid = ($urandom_range(0, 3) != 0);
      bif.tx_data  = W'($urandom);
      bif.bus_gnt  = ($urandom_range(0, 99) < pct);
      @(negedge clk);
    end
    bif.tx_valid = 0; bif.bus_gnt = 1;
    repeat (20) @(negedge clk);
    check("rand_saw_done", n_done > 10, 1);
    check("rand_saw_abort", n_abort > 1, 1);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
